// File: rtl/minority_pkg.sv
// Shared defaults and sizing helper for the minority voter and its popcount.
package minority_pkg;
  localparam int   DEF_WIDTH   = 4;
  localparam logic DEF_TIE_OUT = 1'b0;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/popcount.sv
// Combinational count of set bits across a WIDTH-bit vector.
module popcount
  import minority_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]        in_i,
  output logic [cnt_w(WIDTH)-1:0] cnt_o
);
  localparam int CW = cnt_w(WIDTH);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_o = cnt_o + CW'(in_i[i]);
    end
  end
endmodule

// File: rtl/minority_function.sv
// Registered minority voter: OUT is high when fewer than half the inputs are set.
module minority_function
  import minority_pkg::*;
#(
  parameter int   WIDTH   = DEF_WIDTH,
  parameter logic TIE_OUT = DEF_TIE_OUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        IN,
  output logic                    OUT,
  output logic [cnt_w(WIDTH)-1:0] ONES_CNT,
  output logic                    OUT_VALID
);
  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] HALF = CW'(WIDTH / 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] ones_cnt_q, ones_cnt_d;
  logic          out_q, out_d;
  logic          valid_q, valid_d;

  popcount #(.WIDTH(WIDTH)) u_popcount (
    .in_i (IN),
    .cnt_o(cnt)
  );

  // For odd WIDTH, HALF is (WIDTH-1)/2 and the tie branch can never be reached.
  always_comb begin
    ones_cnt_d = cnt;
    valid_d    = 1'b1;
    out_d      = 1'b0;
    if (WIDTH % 2 == 1) begin
      out_d = (cnt <= HALF);
    end else if (cnt < HALF) begin
      out_d = 1'b1;
    end else if (cnt == HALF) begin
      out_d = TIE_OUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt_q <= '0;
      out_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
    end
  end

  assign OUT       = out_q;
  assign ONES_CNT  = ones_cnt_q;
  assign OUT_VALID = valid_q;
endmodule

// File: tb/tb_minority_function.sv
// Randomized and directed checks of minority_function against a counting reference model.
module tb_minority_function;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in4 = 4'b0000;
  logic [4:0] in5 = 5'b00000;

  logic       out4, out4t, out5;
  logic [2:0] cnt4, cnt4t, cnt5;
  logic       vld4, vld4t, vld5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  minority_function #(.WIDTH(4), .TIE_OUT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .IN(in4), .OUT(out4), .ONES_CNT(cnt4), .OUT_VALID(vld4)
  );
  minority_function #(.WIDTH(4), .TIE_OUT(1'b1)) dut_tie (
    .clk(clk), .rst_n(rst_n), .IN(in4), .OUT(out4t), .ONES_CNT(cnt4t), .OUT_VALID(vld4t)
  );
  minority_function #(.WIDTH(5), .TIE_OUT(1'b0)) dut5 (
    .clk(clk), .rst_n(rst_n), .IN(in5), .OUT(out5), .ONES_CNT(cnt5), .OUT_VALID(vld5)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: fewer ones than zeros -> 1, more -> 0, exactly equal -> tie value.
  function automatic int ref_out(input int ones, input int w, input int tie);
    if (2 * ones < w) return 1;
    if (2 * ones > w) return 0;
    return tie;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every instance against the model for the inputs sampled at the last edge.
  task automatic check_all(input string tag, input logic [3:0] s4, input logic [4:0] s5);
    int o4, o5;
    o4 = $countones(s4);
    o5 = $countones(s5);
    chk({tag, ".out4"},  int'(out4),  ref_out(o4, 4, 0));
    chk({tag, ".cnt4"},  int'(cnt4),  o4);
    chk({tag, ".vld4"},  int'(vld4),  1);
    chk({tag, ".out4t"}, int'(out4t), ref_out(o4, 4, 1));
    chk({tag, ".cnt4t"}, int'(cnt4t), o4);
    chk({tag, ".out5"},  int'(out5),  ref_out(o5, 5, 0));
    chk({tag, ".cnt5"},  int'(cnt5),  o5);
    chk({tag, ".vld5"},  int'(vld5),  1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".out4"},  int'(out4),  0);
    chk({tag, ".cnt4"},  int'(cnt4),  0);
    chk({tag, ".vld4"},  int'(vld4),  0);
    chk({tag, ".out4t"}, int'(out4t), 0);
    chk({tag, ".vld4t"}, int'(vld4t), 0);
    chk({tag, ".out5"},  int'(out5),  0);
    chk({tag, ".cnt5"},  int'(cnt5),  0);
    chk({tag, ".vld5"},  int'(vld5),  0);
  endtask

  initial begin
    logic [3:0] s4;
    logic [4:0] s5;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset("rst_hold");
    end
    rst_n = 1'b1;
    tick();
    check_all("first_after_rst", 4'b0000, 5'b00000);

    // Exhaustive WIDTH=4 sweep with random WIDTH=5 companion
    for (int v = 0; v < 16; v++) begin
      s4 = 4'(v);
      s5 = 5'($urandom_range(0, 31));
      in4 = s4;
      in5 = s5;
      tick();
      check_all($sformatf("sweep%0d", v), s4, s5);
    end

    // Tie cases and directed WIDTH=5 boundaries
    in4 = 4'b0101; in5 = 5'b00011;
    tick();
    check_all("tie_0101", 4'b0101, 5'b00011);
    chk("tie_default_out", int'(out4), 0);
    chk("tie_one_out", int'(out4t), 1);
    chk("w5_two_ones", int'(out5), 1);
    in4 = 4'b1010; in5 = 5'b00111;
    tick();
    check_all("tie_1010", 4'b1010, 5'b00111);
    chk("w5_three_ones", int'(out5), 0);

    // Inputs toggled between edges must not disturb held outputs
    in4 = 4'b1000; in5 = 5'b10000;
    tick();
    check_all("pre_toggle", 4'b1000, 5'b10000);
    #2 in4 = 4'b1111; in5 = 5'b11111;
    #1 check_all("toggle_hi", 4'b1000, 5'b10000);
    #2 in4 = 4'b0000; in5 = 5'b00000;
    #1 check_all("toggle_lo", 4'b1000, 5'b10000);
    in4 = 4'b0011; in5 = 5'b01101;
    tick();
    check_all("toggle_edge", 4'b0011, 5'b01101);

    // Random stream
    for (int i = 0; i < 200; i++) begin
      s4 = 4'($urandom);
      s5 = 5'($urandom);
      in4 = s4;
      in5 = s5;
      tick();
      check_all($sformatf("rand%0d", i), s4, s5);
    end

    // Asynchronous reset between edges while OUT is high
    in4 = 4'b1000; in5 = 5'b00001;
    tick();
    check_all("pre_async", 4'b1000, 5'b00001);
    #2 rst_n = 1'b0;
    #1 check_reset("async_rst_immediate");
    in4 = 4'b0001;
    tick();
    check_reset("async_rst_edge");
    tick();
    check_reset("async_rst_edge2");
    rst_n = 1'b1;
    in4 = 4'b0110; in5 = 5'b11100;
    tick();
    check_all("post_async", 4'b0110, 5'b11100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded budget", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/minority_function.md
MINORITY_FUNCTION -- requirements
Module: minority_function

Interface
REQ-001 Parameter WIDTH, default 4: number of voting inputs; legal range 2..16.
REQ-002 Parameter TIE_OUT, default 1'b0: OUT value when the ones count equals exactly WIDTH/2 (even WIDTH only).
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert handled by the integrator.
REQ-005 Port IN  input  WIDTH  voting inputs, sampled every rising clk edge, no qualifier.
REQ-006 Port OUT  output  1  registered minority result.
REQ-007 Port ONES_CNT  output  $clog2(WIDTH+1)  registered count of ones in the sampled IN.
REQ-008 Port OUT_VALID  output  1  high once OUT/ONES_CNT hold a result computed from a sampled IN.

Function
REQ-009 Each rising clk edge with rst_n high SHALL register ONES_CNT = popcount(IN).
REQ-010 OUT SHALL register 1 when popcount(IN) < WIDTH/2 (strict minority of ones), and 0 when popcount(IN) > WIDTH/2.
REQ-011 When WIDTH is even and popcount(IN) == WIDTH/2, OUT SHALL register TIE_OUT; with WIDTH=4, a count of 2 gives OUT=0 by default.
REQ-012 For odd WIDTH, OUT SHALL be 1 iff popcount(IN) <= (WIDTH-1)/2; no tie case exists.
REQ-013 Latency SHALL be exactly one clock: outputs after edge n reflect IN sampled at edge n; throughput one result per clock.
REQ-014 For WIDTH=4 the OUT truth table SHALL be: 1 for IN in {0000,0001,0010,0100,1000}; 0 for all other 11 codes.
REQ-015 OUT_VALID SHALL rise on the first rising clk edge after rst_n deasserts and SHALL stay high until the next reset.
REQ-016 IN changes between edges SHALL NOT affect outputs; X/Z on IN is out of scope.
REQ-017 No combinational path SHALL exist from IN to any output.

Reset
REQ-018 rst_n low SHALL immediately force OUT=0, ONES_CNT=0, OUT_VALID=0, independent of clk.
REQ-019 Reset asserted mid-operation SHALL discard the in-flight result; the first post-reset edge SHALL produce a fresh result from the IN sampled at that edge.
REQ-020 While rst_n is low, clock edges SHALL NOT update any output.

Structure
REQ-021 A shared package minority_pkg SHALL hold the default WIDTH, the default TIE_OUT, and a function computing the count width $clog2(WIDTH+1).
REQ-022 One sub-module popcount (parameter WIDTH, combinational, output sized by the package function) SHALL compute the ones count; minority_function SHALL instantiate it.
REQ-023 The comparison against WIDTH/2 and the tie resolution SHALL live in minority_function, followed by the output registers.

Verification
REQ-024 Hold rst_n=0 for 3 clocks with IN=4'b0000 -> OUT=0, ONES_CNT=0, OUT_VALID=0 throughout; release -> next edge gives OUT=1, ONES_CNT=0, OUT_VALID=1.
REQ-025 Sweep IN over 0..15, one value per clock -> OUT matches REQ-014 one cycle later (e.g. 4'b0001->1, 4'b0011->0, 4'b0111->0, 4'b1111->0), and ONES_CNT equals popcount.
REQ-026 Tie check, WIDTH=4: IN=4'b0101 -> OUT=0, ONES_CNT=2; repeat with TIE_OUT=1 -> OUT=1.
REQ-027 Assert rst_n low between edges while OUT=1 (IN=4'b1000) -> OUT, ONES_CNT, OUT_VALID drop to 0 at once, without waiting for clk.
REQ-028 Toggle IN between clock edges (4'b0000 to 4'b1111 and back before the next edge) -> outputs unchanged until the edge; the edge samples the value present then.
REQ-029 WIDTH=5 instance: IN=5'b00011 -> OUT=1, ONES_CNT=2; IN=5'b00111 -> OUT=0, ONES_CNT=3.
